// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell consumes an operand bit pair per cycle, LSB first.
// Optional OVERFLOW_FLAG_EN adds the ovf port (two's-complement overflow of the last result).

module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// state | meaning
// IDLE  | waiting for start; s/cout hold the last result
// RUN   | one operand bit pair added per cycle, WIDTH cycles
module serial_adder_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef OVERFLOW_FLAG_EN
   ,output logic             ovf
`endif
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [WIDTH-2:0] res;
    logic [CW-1:0]    count;
    logic             carry;
    logic             load, step, last;
    logic             cell_s, cell_cout;

    full_adder_cell u_cell (
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        step = 1'b0;
        last = 1'b0;
        busy = 1'b0;
        case (state)
            IDLE: load = start;
            RUN: begin
                step = 1'b1;
                busy = 1'b1;
                last = (count == CW'(WIDTH - 1));
            end
            default: ;
        endcase
    end

    // Sum bits enter from the MSB side, so after WIDTH-1 steps bit 0 sits at res[0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_a  <= '0;
            sh_b  <= '0;
            res   <= '0;
            count <= '0;
            carry <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            done  <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (load) begin
                sh_a  <= a;
                sh_b  <= b;
                carry <= cin;
                count <= '0;
            end else if (step) begin
                sh_a  <= sh_a >> 1;
                sh_b  <= sh_b >> 1;
                carry <= cell_cout;
                res   <= (WIDTH-1)'({cell_s, res} >> 1);
                count <= count + CW'(1);
                if (last) begin
                    s    <= {cell_s, res};
                    cout <= cell_cout;
                    done <= 1'b1;
`ifdef OVERFLOW_FLAG_EN
                    ovf  <= carry ^ cell_cout;
`endif
                end
            end
        end
    end
endmodule
